// File: rtl/fix_pkg.sv
// Shared constants, state encoding and ASCII helpers for the FIX field parser.
package fix_pkg;

  localparam logic [7:0]  SOH     = 8'h01;
  localparam logic [7:0]  EQ      = 8'h3D;
  localparam logic [31:0] CHK_TAG = 32'h0000_3031;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TAG  = 2'b01;
  localparam logic [1:0] ERR_VAL  = 2'b10;
  localparam logic [1:0] ERR_SOH  = 2'b11;

  typedef enum logic [1:0] {
    TAG     = 2'd0,
    VALUE   = 2'd1,
    EMIT    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // First byte in [7:0] is the hundreds digit; caller guarantees all three are digits.
  function automatic logic [9:0] ascii3_to_dec(input logic [23:0] b);
    logic [9:0] d0, d1, d2;
    d0 = {6'd0, b[3:0]};
    d1 = {6'd0, b[11:8]};
    d2 = {6'd0, b[19:16]};
    return d0 * 10'd100 + d1 * 10'd10 + d2;
  endfunction

endpackage

// File: rtl/fix_checksum_acc.sv
// Running mod-256 byte sum with a per-field snapshot and a 3-digit ASCII trailer compare.
module fix_checksum_acc
  import fix_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_i,
  input  logic [7:0]  data_i,
  input  logic        snap_i,
  input  logic        clr_i,
  input  logic [23:0] digits_i,
  input  logic        len3_i,
  output logic        chk_ok_o
);

  logic [7:0] sum_q, sum_d;
  logic [7:0] snap_q, snap_d;

  // The snapshot takes the sum before the current byte, i.e. through the previous SOH.
  always_comb begin
    sum_d  = sum_q;
    snap_d = snap_q;
    if (clr_i) begin
      sum_d  = '0;
      snap_d = '0;
    end else begin
      if (snap_i) snap_d = sum_q;
      if (acc_i)  sum_d  = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      snap_q <= '0;
    end else begin
      sum_q  <= sum_d;
      snap_q <= snap_d;
    end
  end

  assign chk_ok_o = len3_i
                 && is_digit(digits_i[7:0])
                 && is_digit(digits_i[15:8])
                 && is_digit(digits_i[23:16])
                 && (ascii3_to_dec(digits_i) == {2'b00, snap_q});

endmodule

// File: rtl/fix_field_parser.sv
// Splits a FIX byte stream into tag/value fields and verifies the "10=" checksum trailer.
module fix_field_parser
  import fix_pkg::*;
#(
  parameter  int VALUE_WIDTH = 256,
  localparam int MAX_VB      = VALUE_WIDTH / 8,
  localparam int VL_W        = $clog2(VALUE_WIDTH / 8 + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             data_i,
  input  logic                   data_valid_i,
  output logic                   ready_o,
  output logic                   field_valid_o,
  input  logic                   field_ready_i,
  output logic [31:0]            tag_o,
  output logic [2:0]             t_len_o,
  output logic [VALUE_WIDTH-1:0] val_o,
  output logic [VL_W-1:0]        v_len_o,
  output logic                   is_chk_o,
  output logic                   chk_ok_o,
  output logic                   msg_end_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o
);

  state_e                 state_q;
  logic                   ready_q, field_valid_q, is_chk_q, chk_ok_q, msg_end_q, err_q;
  logic [1:0]             err_code_q;
  logic [31:0]            tag_q;
  logic [2:0]             t_len_q;
  logic [VALUE_WIDTH-1:0] val_q;
  logic [VL_W-1:0]        v_len_q;

  logic       accept, is_soh, is_eq, handshake, snap_take, chk_clr, tag_is_chk, chk_ok_calc;
  logic       err_det;
  logic [1:0] err_code_det;

  assign accept     = data_valid_i && ready_q;
  assign is_soh     = (data_i == SOH);
  assign is_eq      = (data_i == EQ);
  assign handshake  = field_valid_q && field_ready_i;
  assign snap_take  = accept && (state_q == TAG) && (t_len_q == 3'd0) && !is_soh && !is_eq;
  assign chk_clr    = err_det || (handshake && is_chk_q);
  assign tag_is_chk = (t_len_q == 3'd2) && (tag_q == CHK_TAG);

  always_comb begin
    err_det      = 1'b0;
    err_code_det = ERR_NONE;
    if (accept) begin
      case (state_q)
        TAG: begin
          if (is_soh) begin
            err_det      = 1'b1;
            err_code_det = ERR_SOH;
          end else if (is_eq && (t_len_q == 3'd0)) begin
            err_det      = 1'b1;
            err_code_det = ERR_TAG;
          end else if (!is_eq && (t_len_q == 3'd4)) begin
            err_det      = 1'b1;
            err_code_det = ERR_TAG;
          end
        end
        VALUE: begin
          if (!is_soh && (v_len_q == VL_W'(MAX_VB))) begin
            err_det      = 1'b1;
            err_code_det = ERR_VAL;
          end
        end
        default: ;
      endcase
    end
  end

  fix_checksum_acc u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_i    (accept),
    .data_i   (data_i),
    .snap_i   (snap_take),
    .clr_i    (chk_clr),
    .digits_i (val_q[23:0]),
    .len3_i   (v_len_q == VL_W'(3)),
    .chk_ok_o (chk_ok_calc)
  );

  // ready_q tracks the next state so ready_o is low in reset and in EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TAG;
      ready_q       <= 1'b0;
      field_valid_q <= 1'b0;
      is_chk_q      <= 1'b0;
      chk_ok_q      <= 1'b0;
      msg_end_q     <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      tag_q         <= '0;
      t_len_q       <= '0;
      val_q         <= '0;
      v_len_q       <= '0;
    end else begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      msg_end_q  <= 1'b0;
      ready_q    <= (state_q != EMIT);
      if (err_det) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_det;
        tag_q      <= '0;
        t_len_q    <= '0;
        val_q      <= '0;
        v_len_q    <= '0;
        state_q    <= is_soh ? TAG : DISCARD;
        ready_q    <= 1'b1;
      end else begin
        case (state_q)
          TAG: begin
            if (accept) begin
              if (is_eq) begin
                state_q <= VALUE;
              end else begin
                tag_q[{t_len_q[1:0], 3'b000} +: 8] <= data_i;
                t_len_q <= t_len_q + 3'd1;
              end
            end
          end
          VALUE: begin
            if (accept) begin
              if (is_soh) begin
                state_q       <= EMIT;
                ready_q       <= 1'b0;
                field_valid_q <= 1'b1;
                is_chk_q      <= tag_is_chk;
                chk_ok_q      <= tag_is_chk && chk_ok_calc;
              end else begin
                val_q[{v_len_q, 3'b000} +: 8] <= data_i;
                v_len_q <= v_len_q + VL_W'(1);
              end
            end
          end
          EMIT: begin
            if (field_ready_i) begin
              state_q       <= TAG;
              ready_q       <= 1'b1;
              field_valid_q <= 1'b0;
              msg_end_q     <= is_chk_q;
              is_chk_q      <= 1'b0;
              chk_ok_q      <= 1'b0;
              tag_q         <= '0;
              t_len_q       <= '0;
              val_q         <= '0;
              v_len_q       <= '0;
            end
          end
          DISCARD: begin
            if (accept && is_soh) state_q <= TAG;
          end
          default: state_q <= TAG;
        endcase
      end
    end
  end

  assign ready_o       = ready_q;
  assign field_valid_o = field_valid_q;
  assign tag_o         = tag_q;
  assign t_len_o       = t_len_q;
  assign val_o         = val_q;
  assign v_len_o       = v_len_q;
  assign is_chk_o      = is_chk_q;
  assign chk_ok_o      = chk_ok_q;
  assign msg_end_o     = msg_end_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_fix_field_parser.sv
// Directed self-checking bench for fix_field_parser; '|' in stimulus strings stands for SOH.
module tb_fix_field_parser;

  localparam int VW  = 256;
  localparam int VLW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     data_i;
  logic           data_valid_i;
  logic           ready_o;
  logic           field_valid_o;
  logic           field_ready_i;
  logic [31:0]    tag_o;
  logic [2:0]     t_len_o;
  logic [VW-1:0]  val_o;
  logic [VLW-1:0] v_len_o;
  logic           is_chk_o;
  logic           chk_ok_o;
  logic           msg_end_o;
  logic           err_o;
  logic [1:0]     err_code_o;

  int checks = 0;
  int errors = 0;

  fix_field_parser #(.VALUE_WIDTH(VW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .ready_o       (ready_o),
    .field_valid_o (field_valid_o),
    .field_ready_i (field_ready_i),
    .tag_o         (tag_o),
    .t_len_o       (t_len_o),
    .val_o         (val_o),
    .v_len_o       (v_len_o),
    .is_chk_o      (is_chk_o),
    .chk_ok_o      (chk_ok_o),
    .msg_end_o     (msg_end_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    waitCycles   = 0;
    data_i       = b;
    data_valid_i = 1'b1;
    while (!ready_o && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!ready_o) begin
      checkOutput("readyTimeout", 256'(ready_o), 256'h1);
      data_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    data_valid_i = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++)
      applyStimulus((s[i] == 8'h7C) ? 8'h01 : s[i]);
  endtask

  task automatic consumeField();
    field_ready_i = 1'b1;
    @(negedge clk);
    field_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; data_i = 8'h00; data_valid_i = 1'b0; field_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", 256'(ready_o), 256'h0);
    checkOutput("rstFieldValid", 256'(field_valid_o), 256'h0);
    checkOutput("rstErr", 256'(err_o), 256'h0);
    checkOutput("rstTag", 256'(tag_o), 256'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterRst", 256'(ready_o), 256'h1);

    $display("[TB] single field");
    sendStr("35=A|");
    checkOutput("f1Valid", 256'(field_valid_o), 256'h1);
    checkOutput("f1Tag", 256'(tag_o), 256'h3533);
    checkOutput("f1TLen", 256'(t_len_o), 256'h2);
    checkOutput("f1Val", val_o, 256'h41);
    checkOutput("f1VLen", 256'(v_len_o), 256'h1);
    checkOutput("f1IsChk", 256'(is_chk_o), 256'h0);
    checkOutput("f1ReadyLow", 256'(ready_o), 256'h0);
    consumeField();
    checkOutput("f1Released", 256'(field_valid_o), 256'h0);
    checkOutput("f1NoMsgEnd", 256'(msg_end_o), 256'h0);
    checkOutput("f1ReadyBack", 256'(ready_o), 256'h1);

    $display("[TB] good checksum trailer");
    sendStr("10=231|");
    checkOutput("c1Valid", 256'(field_valid_o), 256'h1);
    checkOutput("c1Tag", 256'(tag_o), 256'h3031);
    checkOutput("c1Val", val_o, 256'h313332);
    checkOutput("c1VLen", 256'(v_len_o), 256'h3);
    checkOutput("c1IsChk", 256'(is_chk_o), 256'h1);
    checkOutput("c1ChkOk", 256'(chk_ok_o), 256'h1);
    consumeField();
    checkOutput("c1MsgEnd", 256'(msg_end_o), 256'h1);
    @(negedge clk);
    checkOutput("c1MsgEndPulse", 256'(msg_end_o), 256'h0);

    $display("[TB] wrong checksum value");
    sendStr("35=A|");
    consumeField();
    sendStr("10=232|");
    checkOutput("c2IsChk", 256'(is_chk_o), 256'h1);
    checkOutput("c2ChkOk", 256'(chk_ok_o), 256'h0);
    consumeField();
    checkOutput("c2MsgEnd", 256'(msg_end_o), 256'h1);

    $display("[TB] short checksum value");
    sendStr("35=A|");
    consumeField();
    sendStr("10=23|");
    checkOutput("c3IsChk", 256'(is_chk_o), 256'h1);
    checkOutput("c3ChkOk", 256'(chk_ok_o), 256'h0);
    checkOutput("c3VLen", 256'(v_len_o), 256'h2);
    consumeField();
    checkOutput("c3MsgEnd", 256'(msg_end_o), 256'h1);

    $display("[TB] consumer stall");
    sendStr("35=A|");
    data_i = 8'h39;
    data_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stallValid", 256'(field_valid_o), 256'h1);
      checkOutput("stallReady", 256'(ready_o), 256'h0);
      checkOutput("stallTag", 256'(tag_o), 256'h3533);
    end
    field_ready_i = 1'b1;
    @(negedge clk);
    field_ready_i = 1'b0;
    checkOutput("stallReleased", 256'(field_valid_o), 256'h0);
    checkOutput("stallReadyBack", 256'(ready_o), 256'h1);
    checkOutput("stallTagCleared", 256'(tag_o), 256'h0);
    @(negedge clk);
    data_valid_i = 1'b0;
    checkOutput("stallByteKept", 256'(tag_o), 256'h39);
    sendStr("=Z|");
    checkOutput("stallFieldTag", 256'(tag_o), 256'h39);
    checkOutput("stallFieldTLen", 256'(t_len_o), 256'h1);
    checkOutput("stallFieldVal", val_o, 256'h5A);
    consumeField();

    $display("[TB] tag too long then resync");
    sendStr("1234");
    applyStimulus(8'h35);
    checkOutput("longTagErr", 256'(err_o), 256'h1);
    checkOutput("longTagCode", 256'(err_code_o), 256'h1);
    checkOutput("longTagCleared", 256'(tag_o), 256'h0);
    @(negedge clk);
    checkOutput("longTagErrPulse", 256'(err_o), 256'h0);
    sendStr("=X|");
    checkOutput("discardNoField", 256'(field_valid_o), 256'h0);
    sendStr("55=B|");
    checkOutput("resyncValid", 256'(field_valid_o), 256'h1);
    checkOutput("resyncTag", 256'(tag_o), 256'h3535);
    checkOutput("resyncVal", val_o, 256'h42);
    consumeField();

    $display("[TB] value too long");
    sendStr("7=");
    for (int i = 0; i < 32; i++) applyStimulus(8'h61);
    checkOutput("fullValNoErr", 256'(err_o), 256'h0);
    checkOutput("fullValVLen", 256'(v_len_o), 256'd32);
    applyStimulus(8'h62);
    checkOutput("longValErr", 256'(err_o), 256'h1);
    checkOutput("longValCode", 256'(err_code_o), 256'h2);
    checkOutput("longValCleared", 256'(v_len_o), 256'h0);
    sendStr("|");

    $display("[TB] empty tag");
    applyStimulus(8'h3D);
    checkOutput("emptyTagErr", 256'(err_o), 256'h1);
    checkOutput("emptyTagCode", 256'(err_code_o), 256'h1);
    sendStr("X|");

    $display("[TB] SOH inside tag");
    sendStr("4");
    applyStimulus(8'h01);
    checkOutput("sohTagErr", 256'(err_o), 256'h1);
    checkOutput("sohTagCode", 256'(err_code_o), 256'h3);
    sendStr("8=C|");
    checkOutput("sohResyncValid", 256'(field_valid_o), 256'h1);
    checkOutput("sohResyncTag", 256'(tag_o), 256'h38);
    consumeField();

    $display("[TB] reset mid-value");
    sendStr("35=AB");
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 256'(field_valid_o), 256'h0);
    checkOutput("midRstReady", 256'(ready_o), 256'h0);
    checkOutput("midRstVal", val_o, 256'h0);
    checkOutput("midRstVLen", 256'(v_len_o), 256'h0);
    checkOutput("midRstTag", 256'(tag_o), 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01);
    checkOutput("postRstNoField", 256'(field_valid_o), 256'h0);
    checkOutput("postRstSohErr", 256'(err_code_o), 256'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
